// File: rtl/mem_load_ctrl.sv
// mem_load_ctrl: boot-time load sequencer for the 32-word register-file memory.
// Accepts a valid/ready word stream and writes it to consecutive addresses from 0
// through the memory loader port, holding the CPU until the last write commits.
// Optional trailing-checksum verification is enabled by defining MEM_LOAD_CKSUM_EN.
module mem_load_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        load_count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] memaddr,
  output logic [DATA_W-1:0] memin,
  output logic              memwe,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [5:0]        words_loaded
`ifdef MEM_LOAD_CKSUM_EN
  ,
  output logic              cksum_err
`endif
);

  localparam logic [5:0] MAX_WORDS = 6'd32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
`ifdef MEM_LOAD_CKSUM_EN
    CHECK = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [5:0]        target_r;
  logic [5:0]        words_r;
  logic [ADDR_W-1:0] memaddr_r;
  logic [DATA_W-1:0] memin_r;
  logic              memwe_r;
  logic              in_ready_r;
  logic              cpu_hold_r;
  logic              busy_r;
  logic              done_r;
  logic [5:0]        clamp_s;
  logic              accept_s;
  logic              last_s;
  logic              ready_next_s;
`ifdef MEM_LOAD_CKSUM_EN
  logic [DATA_W-1:0] sum_r;
  logic              cksum_err_r;
`endif

  // Next-state decode: clamp the requested count, detect accepts and the final data word.
  always_comb begin
    next_state_s = state_r;
    ready_next_s = 1'b0;
    clamp_s      = (load_count > MAX_WORDS) ? MAX_WORDS : load_count;
    accept_s     = in_valid & in_ready_r;
    last_s       = accept_s && ((words_r + 6'd1) == target_r);
    case (state_r)
      IDLE: begin
        if (start) begin
          if (clamp_s == 6'd0) begin
            next_state_s = DONE;
          end else begin
            next_state_s = LOAD;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (last_s) begin
`ifdef MEM_LOAD_CKSUM_EN
          next_state_s = CHECK;
`else
          next_state_s = DONE;
`endif
        end else begin
          next_state_s = LOAD;
        end
      end
`ifdef MEM_LOAD_CKSUM_EN
      CHECK: begin
        if (accept_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = CHECK;
        end
      end
`endif
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
`ifdef MEM_LOAD_CKSUM_EN
    if ((next_state_s == LOAD) || (next_state_s == CHECK)) begin
      ready_next_s = 1'b1;
    end else begin
      ready_next_s = 1'b0;
    end
`else
    if (next_state_s == LOAD) begin
      ready_next_s = 1'b1;
    end else begin
      ready_next_s = 1'b0;
    end
`endif
  end

  // State, registered handshake/status outputs and the one-cycle loader write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      target_r    <= 6'd0;
      words_r     <= 6'd0;
      memaddr_r   <= '0;
      memin_r     <= '0;
      memwe_r     <= 1'b0;
      in_ready_r  <= 1'b0;
      cpu_hold_r  <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef MEM_LOAD_CKSUM_EN
      sum_r       <= '0;
      cksum_err_r <= 1'b0;
`endif
    end else begin
      state_r    <= next_state_s;
      in_ready_r <= ready_next_s;
      busy_r     <= (next_state_s != IDLE);
      done_r     <= (next_state_s == DONE);
      memwe_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            target_r    <= clamp_s;
            words_r     <= 6'd0;
            cpu_hold_r  <= 1'b1;
`ifdef MEM_LOAD_CKSUM_EN
            sum_r       <= '0;
            cksum_err_r <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (accept_s) begin
            memaddr_r <= words_r[ADDR_W-1:0];
            memin_r   <= in_data;
            memwe_r   <= 1'b1;
            words_r   <= words_r + 6'd1;
`ifdef MEM_LOAD_CKSUM_EN
            sum_r     <= sum_r + in_data;
`endif
          end
        end
`ifdef MEM_LOAD_CKSUM_EN
        CHECK: begin
          if (accept_s && (in_data != sum_r)) begin
            cksum_err_r <= 1'b1;
          end
        end
`endif
        DONE:    cpu_hold_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign memaddr      = memaddr_r;
  assign memin        = memin_r;
  assign memwe        = memwe_r;
  assign cpu_hold     = cpu_hold_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign words_loaded = words_r;
`ifdef MEM_LOAD_CKSUM_EN
  assign cksum_err    = cksum_err_r;
`endif

endmodule

// File: tb/tb_mem_load_ctrl.sv
// tb_mem_load_ctrl: directed bench for mem_load_ctrl with a small memory model
// on the loader write port. Builds with or without MEM_LOAD_CKSUM_EN.
module tb_mem_load_ctrl;

`ifdef MEM_LOAD_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [5:0]  load_count;
  logic [31:0] in_data;
  logic        in_ready, memwe, cpu_hold, busy, done;
  logic [4:0]  memaddr;
  logic [31:0] memin;
  logic [5:0]  words_loaded;
`ifdef MEM_LOAD_CKSUM_EN
  logic        cksum_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];
  int          wr_cnt;
  int          done_cnt;
  logic [31:0] wr_mask;
  logic        clr_mon;

  mem_load_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .load_count(load_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .memaddr(memaddr), .memin(memin), .memwe(memwe), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .words_loaded(words_loaded)
`ifdef MEM_LOAD_CKSUM_EN
    , .cksum_err(cksum_err)
`endif
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Memory model plus write/done monitors.
  always @(posedge clk) begin
    if (clr_mon) begin
      wr_cnt   <= 0;
      done_cnt <= 0;
      wr_mask  <= '0;
    end else begin
      if (memwe) begin
        mem[memaddr]     <= memin;
        wr_cnt           <= wr_cnt + 1;
        wr_mask[memaddr] <= 1'b1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    tick();
    clr_mon = 1'b0;
  endtask

  // Directed stimulus and checks.
  initial begin
    logic [31:0] d4 [4];
    logic [31:0] sum;
    logic        rdy, acc, seen;
    int          k, nacc;
    d4[0] = 32'h11; d4[1] = 32'h22; d4[2] = 32'h33; d4[3] = 32'h44;

    reset = 1'b1; start = 1'b0; load_count = 6'd0; in_valid = 1'b0;
    in_data = 32'd0; clr_mon = 1'b1;
    tick(); tick();
    reset = 1'b0; clr_mon = 1'b0;

    // Reset state and 5 idle cycles
    chk("rst_memaddr", 32'(memaddr), 32'd0);
    chk("rst_memin", memin, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef MEM_LOAD_CKSUM_EN
    chk("rst_cksum_err", 32'(cksum_err), 32'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      chk("idle_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("idle_memwe", 32'(memwe), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      tick();
    end

    // 4-word back-to-back load
    clear_mon();
    start = 1'b1; load_count = 6'd4;
    tick();
    start = 1'b0;
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = d4[i];
      tick();
      chk("t2_memwe", 32'(memwe), 32'd1);
      chk("t2_memaddr", 32'(memaddr), 32'(i));
      chk("t2_memin", memin, d4[i]);
      chk("t2_done", 32'(done), ((i == 3) && (CK == 0)) ? 32'd1 : 32'd0);
      chk("t2_cpu_hold", 32'(cpu_hold), 32'd1);
    end
    in_valid = 1'b0;
`ifdef MEM_LOAD_CKSUM_EN
    feed(32'h000000AA);
    chk("t2_ck_memwe", 32'(memwe), 32'd0);
    chk("t2_ck_err", 32'(cksum_err), 32'd0);
`endif
    chk("t2_done_cycle", 32'(done), 32'd1);
    chk("t2_ready_done", 32'(in_ready), 32'd0);
    tick();
    chk("t2_release", 32'(cpu_hold), 32'd0);
    chk("t2_busy_off", 32'(busy), 32'd0);
    chk("t2_memwe_off", 32'(memwe), 32'd0);
    chk("t2_addr_hold", 32'(memaddr), 32'd3);
    chk("t2_words", 32'(words_loaded), 32'd4);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_wr_cnt", 32'(wr_cnt), 32'd4);
    chk("t2_mem2", mem[2], 32'h33);

    // 32 words with in_valid toggling
    clear_mon();
    start = 1'b1; load_count = 6'd32;
    tick();
    start = 1'b0;
    k = 0; sum = 32'd0; seen = 1'b0;
    for (int c = 0; (c < 300) && !seen; c++) begin
      rdy      = in_ready;
      in_valid = c[0];
      in_data  = (k < 32) ? (32'hC0DE0000 | 32'(k)) : sum;
      tick();
      acc = in_valid && rdy;
      if (acc) begin
        if (k < 32) sum = sum + in_data;
        k++;
      end
      chk("t3_wr_follow", 32'(memwe), 32'(acc && (k <= 32)));
      if (done) seen = 1'b1;
    end
    in_valid = 1'b0;
    chk("t3_done_seen", 32'(seen), 32'd1);
    tick();
    chk("t3_words", 32'(words_loaded), 32'd32);
    chk("t3_wr_cnt", 32'(wr_cnt), 32'd32);
    chk("t3_mask", wr_mask, 32'hFFFFFFFF);
    chk("t3_mem0", mem[0], 32'hC0DE0000);
    chk("t3_mem31", mem[31], 32'hC0DE001F);
    chk("t3_release", 32'(cpu_hold), 32'd0);
`ifdef MEM_LOAD_CKSUM_EN
    chk("t3_ck_err", 32'(cksum_err), 32'd0);
`endif

    // load_count=40 clamps to 32
    clear_mon();
    start = 1'b1; load_count = 6'd40;
    tick();
    start = 1'b0;
    nacc = 0;
    for (int c = 0; c < 40; c++) begin
      rdy      = in_ready;
      in_valid = 1'b1;
      in_data  = 32'h40000000 | 32'(nacc);
      tick();
      if (rdy) begin
        nacc++;
        if (nacc == 32) chk("t4_ready_after32", 32'(in_ready), 32'(CK));
      end
    end
    in_valid = 1'b0;
    chk("t4_accepts", 32'(nacc), 32'(32 + CK));
    chk("t4_wr_cnt", 32'(wr_cnt), 32'd32);
    chk("t4_words", 32'(words_loaded), 32'd32);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_release", 32'(cpu_hold), 32'd0);

    // Zero count
    clear_mon();
    start = 1'b1; load_count = 6'd0;
    tick();
    start = 1'b0;
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_memwe", 32'(memwe), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd0);
    chk("t5_hold", 32'(cpu_hold), 32'd1);
    tick();
    chk("t5_release", 32'(cpu_hold), 32'd0);
    chk("t5_done_off", 32'(done), 32'd0);
    chk("t5_wr_cnt", 32'(wr_cnt), 32'd0);

    // start held during a 3-word load is ignored
    clear_mon();
    start = 1'b1; load_count = 6'd3;
    tick();
    load_count = 6'd5;
    for (int i = 0; i < 3; i++) feed(32'h600 + 32'(i));
`ifdef MEM_LOAD_CKSUM_EN
    feed(32'h1803);
`endif
    chk("t6_done", 32'(done), 32'd1);
    start = 1'b0;
    tick();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_wr_cnt", 32'(wr_cnt), 32'd3);
    chk("t6_words", 32'(words_loaded), 32'd3);
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);

    // Reset after 2 of 5 words
    clear_mon();
    start = 1'b1; load_count = 6'd5;
    tick();
    start = 1'b0;
    feed(32'hDEAD0000);
    feed(32'hDEAD0001);
    chk("t7_memwe_pre", 32'(memwe), 32'd1);
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD0002;
    tick();
    chk("t7_memwe", 32'(memwe), 32'd0);
    chk("t7_hold", 32'(cpu_hold), 32'd1);
    chk("t7_ready", 32'(in_ready), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_words", 32'(words_loaded), 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk("t7_mem0", mem[0], 32'hDEAD0000);
    chk("t7_mem1", mem[1], 32'hDEAD0001);
    chk("t7_mem2", mem[2], 32'h602);
    chk("t7_wr_cnt", 32'(wr_cnt), 32'd2);

`ifdef MEM_LOAD_CKSUM_EN
    // Checksum good then bad
    start = 1'b1; load_count = 6'd3;
    tick();
    start = 1'b0;
    feed(32'd1); feed(32'd2); feed(32'd3);
    chk("t8_ready_check", 32'(in_ready), 32'd1);
    feed(32'd6);
    chk("t8_good_done", 32'(done), 32'd1);
    chk("t8_good_err", 32'(cksum_err), 32'd0);
    tick();
    chk("t8_good_release", 32'(cpu_hold), 32'd0);
    start = 1'b1; load_count = 6'd3;
    tick();
    start = 1'b0;
    feed(32'd1); feed(32'd2); feed(32'd3); feed(32'd7);
    chk("t8_bad_done", 32'(done), 32'd1);
    chk("t8_bad_err", 32'(cksum_err), 32'd1);
    tick();
    chk("t8_bad_sticky", 32'(cksum_err), 32'd1);
    chk("t8_bad_release", 32'(cpu_hold), 32'd0);
    start = 1'b1; load_count = 6'd0;
    tick();
    start = 1'b0;
    chk("t8_err_cleared", 32'(cksum_err), 32'd0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_load_ctrl.md
# mem_load_ctrl

Boot-time load sequencer for the 32-word, 32-bit register-file memory. It accepts a stream of program/data words over a valid/ready handshake and writes them to consecutive addresses starting at 0 through the memory's loader write port (memaddr/memin/memwe). While loading, it holds the CPU. When the last write has committed, it releases the CPU. The block sits between the host/testbench stream source and the memory's loader port; the CPU-side port is untouched.

## Interface

Parameters:
- ADDR_W, 5, memory address width (32 words).
- DATA_W, 32, memory word width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- load_count  in  6  words to load, captured on accepted start; 0 = none; values >32 clamp to 32.
- in_data  in  32  stream word.
- in_valid  in  1  stream word valid.
- in_ready  out  1  block accepts in_data this cycle.
- memaddr  out  5  loader write address to memory.
- memin  out  32  loader write data to memory.
- memwe  out  1  loader write enable; overrides the CPU write port in memory.
- cpu_hold  out  1  CPU stall/reset request.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, load complete.
- words_loaded  out  6  words written in the current/last load.
- cksum_err  out  1  sticky checksum mismatch; present only with MEM_LOAD_CKSUM_EN.

## Operation

- **States:** IDLE, LOAD, CHECK (only with MEM_LOAD_CKSUM_EN), DONE.
- **IDLE**
  - in_ready=0.
  - If start=1: capture the clamped load_count, clear words_loaded and the address counter, and clear cksum_err. Go to LOAD, or to DONE if the count is 0.
  - cpu_hold=1 from the start edge onward.
- **LOAD**
  - in_ready=1.
  - A word is accepted when in_valid and in_ready are both 1 at a rising edge.
  - On accept: register memaddr=counter, memin=in_data, memwe=1 for the next cycle only. Then counter+1 and words_loaded+1.
  - When the accepted count reaches load_count: go to DONE, or CHECK if checksum is enabled.
- **CHECK**
  - in_ready=1. The next accepted word is compared to the running sum; no memory write.
  - If the word differs from the sum, set cksum_err. Then go to DONE.
- **DONE**
  - Lasts one cycle with done=1 and in_ready=0. Then go to IDLE and clear cpu_hold.
- **start handling:** start is ignored in LOAD, CHECK and DONE.
- **Counter limits:** the address counter never wraps within a load; the maximum is 32 words, addresses 0..31.
- **Idle write port:** memaddr and memin hold their last value when memwe=0.

## Timing

- **Reset values:** state=IDLE, in_ready=0, memwe=0, memaddr=0, memin=0, cpu_hold=1, busy=0, done=0, words_loaded=0, cksum_err=0.
  - The CPU stays held after reset until the first completed load.
- **Start latency:** start at edge E0 means busy=1 and in_ready=1 in the cycle after E0.
- **Write latency:** a word accepted at edge Ek has memwe=1 during cycle k+1, and the memory commits it at edge Ek+1.
- **Throughput:** one word per cycle; in_valid may stall arbitrarily.
- **Last word:**
  - The last data word is accepted at edge En; its memwe cycle coincides with DONE (or CHECK).
  - done is high in the DONE cycle.
  - cpu_hold falls at the edge ending DONE, after the last write has committed.
- **Zero count:** load_count=0 gives DONE in the cycle after start, no memwe, and cpu_hold=0 one cycle later.
- **Reset mid-load:** return to reset values on that edge and drop memwe immediately.
  - Words already written remain in memory; memory reset is separate.
  - cpu_hold returns to 1.
- **Back-pressure:** in_valid=1 while in_ready=0 is not consumed; the source must hold the word.

## Configuration

- **MEM_LOAD_CKSUM_EN defined:**
  - A 32-bit running sum (modulo 2^32) of all written words is kept.
  - The CHECK state consumes one trailing checksum word.
  - The cksum_err port exists; it is sticky until the next accepted start or reset.
  - done still pulses on a mismatch, and cpu_hold is still released.
- **MEM_LOAD_CKSUM_EN undefined:**
  - No sum register, no CHECK state and no cksum_err port.
  - LOAD goes directly to DONE after the last word.

## Test plan

- Reset, then idle 5 cycles: expect cpu_hold=1, memwe=0, in_ready=0 and busy=0 throughout.
- start with load_count=4 and words 0x11,0x22,0x33,0x44 back-to-back: expect memwe pulses at addresses 0..3 one cycle after each accept, done once, cpu_hold=0 two cycles after the last accept, and the CPU port reading address 2 returns 0x33.
- load_count=32 with in_valid toggling every other cycle: expect all 32 addresses written, words_loaded=32, no address wrap, and no write while in_valid=0.
- load_count=40: expect clamp, exactly 32 writes, and in_ready=0 after the 32nd accept.
- load_count=0: expect done in the cycle after start, zero memwe, and cpu_hold=0 on the next cycle. A start asserted during LOAD of a 3-word load is ignored: exactly 3 writes.
- Reset asserted after 2 of 5 words: expect memwe=0 and cpu_hold=1 on the next cycle and words 0..1 retained. With MEM_LOAD_CKSUM_EN, words 1,2,3 plus trailing 6 give cksum_err=0, while a trailing 7 gives cksum_err=1.
